// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Multi-cycle integer multiply / divide engine for the EX stage. It computes
// the 64-bit {HI,LO} pair for MULT, MULTU, DIV, DIVU, MADD and MSUB and loads
// it into the HI/LO registers with a single strobe. Start/Busy/Done let the
// hazard unit stall MFHI/MFLO and back-to-back multiply/divide instructions.
//
// Operation sequence:
//   IDLE -> RUN (WIDTH iterations) -> FIX (sign / accumulate) -> DONE -> IDLE
//   Busy covers RUN, FIX and DONE (WIDTH+2 cycles). Done is the last of them.
//
// Ports:
//   Clk     in   system clock, rising edge
//   Clr     in   asynchronous active-low reset
//   Start   in   launch request, honoured only in IDLE with a valid Op
//   Op      in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB
//   A       in   rs operand (multiplicand / dividend)
//   B       in   rt operand (multiplier / divisor)
//   HI_in   in   current HI value, accumulate source for MADD/MSUB
//   LO_in   in   current LO value, accumulate source for MADD/MSUB
//   Busy    out  high while the engine is not IDLE
//   Done    out  one-cycle completion pulse
//   HI_Ld   out  HI register load strobe (same as Done)
//   LO_Ld   out  LO register load strobe (same as Done)
//   HI_out  out  product high word / remainder
//   LO_out  out  product low word / quotient
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] HI_in,
  input  logic [WIDTH-1:0] LO_in,
  output logic             Busy,
  output logic             Done,
  output logic             HI_Ld,
  output logic             LO_Ld,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t             state_q,   state_d;
  logic [2:0]         op_q,      op_d;
  // Magnitude of the multiplicand (multiply) or of the divisor (divide).
  logic [WIDTH-1:0]   m_q,       m_d;
  // Working pair. Multiply: {partial product high, multiplier/product low}.
  // Divide: {partial remainder, dividend bits shifting into quotient}.
  logic [WIDTH-1:0]   p_hi_q,    p_hi_d;
  logic [WIDTH-1:0]   p_lo_q,    p_lo_d;
  // {HI_in,LO_in} captured at launch for MADD/MSUB.
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  // Result negation (operand signs differ) and remainder sign (dividend < 0).
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [WIDTH-1:0]   hi_out_q,  hi_out_d;
  logic [WIDTH-1:0]   lo_out_q,  lo_out_d;

  // ---------------------------------------------------------------------
  // Launch-time operand decode
  // ---------------------------------------------------------------------
  logic             op_valid;
  logic             op_signed_in;
  logic             op_div_in;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    op_valid     = (Op <= OP_MSUB);
    op_signed_in = (Op == OP_MULT) || (Op == OP_DIV) ||
                   (Op == OP_MADD) || (Op == OP_MSUB);
    op_div_in    = (Op == OP_DIV) || (Op == OP_DIVU);
    a_neg        = op_signed_in && A[WIDTH-1];
    b_neg        = op_signed_in && B[WIDTH-1];
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    a_mag        = a_neg ? -A : A;
    b_mag        = b_neg ? -B : B;
  end

  // ---------------------------------------------------------------------
  // One iteration of the datapath
  // ---------------------------------------------------------------------
  logic             is_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  always_comb begin
    is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    // Shift-add: add the multiplicand when the current multiplier bit is set,
    // keeping the carry so the following right shift loses nothing.
    mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    // Restoring divide: bring down the next dividend bit and try a subtract.
    // The shifted remainder is below 2*divisor, so WIDTH+1 bits are enough
    // and a successful difference always fits back into WIDTH bits.
    div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, m_q});
    div_diff  = div_shift[WIDTH-1:0] - m_q;
  end

  // ---------------------------------------------------------------------
  // Final sign correction / accumulation
  // ---------------------------------------------------------------------
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_signed;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] fix_res;

  always_comb begin
    product        = {p_hi_q, p_lo_q};
    product_signed = neg_res_q ? -product : product;

    // Divide by zero leaves the full dividend magnitude as the remainder,
    // which after the dividend-sign fix is the original A. The quotient is
    // forced to all ones regardless of the operand signs.
    if (m_q == '0) begin
      quot = '1;
    end else begin
      quot = neg_res_q ? -p_lo_q : p_lo_q;
    end
    rem = neg_rem_q ? -p_hi_q : p_hi_q;

    case (op_q)
      OP_MADD:         fix_res = acc_q + product_signed;
      OP_MSUB:         fix_res = acc_q - product_signed;
      OP_DIV, OP_DIVU: fix_res = {rem, quot};
      default:         fix_res = product_signed;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    m_d       = m_q;
    p_hi_d    = p_hi_q;
    p_lo_d    = p_lo_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_out_d  = hi_out_q;
    lo_out_d  = lo_out_q;

    case (state_q)
      S_IDLE: begin
        if (Start && op_valid) begin
          op_d      = Op;
          acc_d     = {HI_in, LO_in};
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = '0;
          p_hi_d    = '0;
          if (op_div_in) begin
            m_d    = b_mag;
            p_lo_d = a_mag;
          end else begin
            m_d    = a_mag;
            p_lo_d = b_mag;
          end
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (is_div) begin
          if (div_ge) begin
            p_hi_d = div_diff;
            p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            p_hi_d = div_shift[WIDTH-1:0];
            p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          p_hi_d = mul_sum[WIDTH:1];
          p_lo_d = {mul_sum[0], p_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        hi_out_d = fix_res[2*WIDTH-1:WIDTH];
        lo_out_d = fix_res[WIDTH-1:0];
        state_d  = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      m_q       <= '0;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_out_q  <= '0;
      lo_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      m_q       <= m_d;
      p_hi_q    <= p_hi_d;
      p_lo_q    <= p_lo_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_out_q  <= hi_out_d;
      lo_out_q  <= lo_out_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign Busy   = (state_q != S_IDLE);
  assign Done   = (state_q == S_DONE);
  assign HI_Ld  = Done;
  assign LO_Ld  = Done;
  assign HI_out = hi_out_q;
  assign LO_out = lo_out_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit (WIDTH=32). Expected HI/LO values come
// from a plain-arithmetic reference function; latency and strobe behaviour
// are checked against fixed cycle counts.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
  localparam int W       = 32;
  localparam int LATENCY = 34;   // Busy cycles; Done is the last one

  logic         Clk;
  logic         Clr;
  logic         Start;
  logic [2:0]   Op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] HI_in;
  logic [W-1:0] LO_in;
  logic         Busy;
  logic         Done;
  logic         HI_Ld;
  logic         LO_Ld;
  logic [W-1:0] HI_out;
  logic [W-1:0] LO_out;

  int vectors     = 0;
  int miscompares = 0;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk    (Clk),
    .Clr    (Clr),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .HI_in  (HI_in),
    .LO_in  (LO_in),
    .Busy   (Busy),
    .Done   (Done),
    .HI_Ld  (HI_Ld),
    .LO_Ld  (LO_Ld),
    .HI_out (HI_out),
    .LO_out (LO_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: the architectural result of each operation as {HI,LO}.
  function automatic logic [63:0] model(input logic [2:0] op,
                                        input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] hi, input logic [W-1:0] lo);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0]        ua, ub, acc, res;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {hi, lo};
    res = 64'd0;
    case (op)
      3'd0: res = sa * sb;
      3'd1: res = ua * ub;
      3'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          res = {32'(ua % ub), 32'(ua / ub)};
        end
      end
      3'd4: res = acc + sa * sb;
      3'd5: res = acc - sa * sb;
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b; HI_in = hi; LO_in = lo;
    @(negedge Clk);
    // Scramble the operand bus: the latched values must be what counts.
    Start = 1'b0;
    Op    = 3'($urandom_range(0, 7));
    A     = $urandom; B = $urandom; HI_in = $urandom; LO_in = $urandom;
  endtask

  // Run one operation to completion and check latency, strobes and result.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo);
    logic [63:0] exp;
    int cyc;
    int busy_low;
    exp      = model(op, a, b, hi, lo);
    launch(op, a, b, hi, lo);
    cyc      = 1;
    busy_low = 0;
    while (Done !== 1'b1 && cyc < LATENCY + 20) begin
      if (Busy !== 1'b1) busy_low++;
      @(negedge Clk);
      cyc++;
    end
    vectors++;
    if (cyc != LATENCY) begin
      miscompares++;
      $display("FAIL latency op=%0d: Done in busy cycle %0d, expected %0d", op, cyc, LATENCY);
    end
    vectors++;
    if (busy_low != 0) begin
      miscompares++;
      $display("FAIL busy_hold op=%0d: Busy low for %0d cycles before Done, expected 0", op, busy_low);
    end
    vectors++;
    if ({Busy, HI_Ld, LO_Ld} !== 3'b111) begin
      miscompares++;
      $display("FAIL done_strobes op=%0d: {Busy,HI_Ld,LO_Ld}=%b expected 111", op, {Busy, HI_Ld, LO_Ld});
    end
    vectors++;
    if ({HI_out, LO_out} !== exp) begin
      miscompares++;
      $display("FAIL result op=%0d a=%h b=%h hi=%h lo=%h: got %h_%h expected %h_%h",
               op, a, b, hi, lo, HI_out, LO_out, exp[63:32], exp[31:0]);
    end
    @(negedge Clk);
    vectors++;
    if ({Busy, Done, HI_Ld, LO_Ld} !== 4'b0000 || {HI_out, LO_out} !== exp) begin
      miscompares++;
      $display("FAIL after_done op=%0d: {Busy,Done,HI_Ld,LO_Ld}=%b out=%h_%h expected 0000 %h_%h",
               op, {Busy, Done, HI_Ld, LO_Ld}, HI_out, LO_out, exp[63:32], exp[31:0]);
    end
    $display("op=%0d a=%h b=%h hi=%h lo=%h -> HI_out=%h LO_out=%h (latency %0d)",
             op, a, b, hi, lo, HI_out, LO_out, cyc);
  endtask

  task automatic test_reset;
    Clr = 1'b0; Start = 1'b0; Op = 3'd0; A = '0; B = '0; HI_in = '0; LO_in = '0;
    repeat (3) @(negedge Clk);
    vectors++;
    if ({Busy, Done, HI_Ld, LO_Ld} !== 4'b0000 || HI_out !== '0 || LO_out !== '0) begin
      miscompares++;
      $display("FAIL reset_state: {Busy,Done,HI_Ld,LO_Ld}=%b HI_out=%h LO_out=%h expected all zero",
               {Busy, Done, HI_Ld, LO_Ld}, HI_out, LO_out);
    end
    Clr = 1'b1;
    @(negedge Clk);
    $display("reset released: Busy=%b HI_out=%h LO_out=%h", Busy, HI_out, LO_out);
  endtask

  task automatic test_directed;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);        // MULTU max
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h0);                // MULT -3*7
    run_op(3'd4, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF);                // MADD carry
    run_op(3'd5, 32'd1, 32'd1, 32'h0, 32'h0);                        // MSUB wrap
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0);                // DIV -7/2
    run_op(3'd3, 32'd100, 32'd7, 32'h0, 32'h0);                      // DIVU 100/7
    run_op(3'd3, 32'h0000_1234, 32'd0, 32'h0, 32'h0);                // DIVU by zero
    run_op(3'd2, 32'hFFFF_FF00, 32'd0, 32'h0, 32'h0);                // DIV negative by zero
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);        // DIV overflow
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0);        // MULT min*min
    run_op(3'd5, 32'hFFFF_FFFF, 32'd5, 32'h1234_5678, 32'h9ABC_DEF0); // MSUB negative product
  endtask

  task automatic test_random;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(op, a, b, $urandom, $urandom);
    end
  endtask

  task automatic test_reserved_op;
    int stray;
    for (int k = 6; k <= 7; k++) begin
      @(negedge Clk);
      Start = 1'b1; Op = 3'(k); A = $urandom; B = $urandom;
      @(negedge Clk);
      Start = 1'b0;
      stray = 0;
      for (int c = 0; c < 40; c++) begin
        if (Busy !== 1'b0 || Done !== 1'b0) stray++;
        @(negedge Clk);
      end
      vectors++;
      if (stray != 0) begin
        miscompares++;
        $display("FAIL reserved_op op=%0d: Busy/Done active %0d cycles, expected 0", k, stray);
      end
      $display("reserved op=%0d: Busy/Done active cycles=%0d", k, stray);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp;
    int cyc;
    int pulses;
    exp    = model(3'd1, 32'd12345, 32'd678, 32'h0, 32'h0);
    launch(3'd1, 32'd12345, 32'd678, 32'h0, 32'h0);
    cyc    = 1;
    pulses = 0;
    while (Done !== 1'b1 && cyc < LATENCY + 20) begin
      // A second request in the middle of the run must be dropped.
      if (cyc == 5) begin
        Start = 1'b1; Op = 3'd3; A = 32'd1; B = 32'd1;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk);
      cyc++;
    end
    // Another request during the DONE cycle must also be dropped.
    Start = 1'b1; Op = 3'd0; A = 32'd3; B = 32'd3;
    if (Done === 1'b1) pulses++;
    vectors++;
    if ({HI_out, LO_out} !== exp || cyc != LATENCY) begin
      miscompares++;
      $display("FAIL b2b_result: got %h_%h in cycle %0d expected %h_%h in cycle %0d",
               HI_out, LO_out, cyc, exp[63:32], exp[31:0], LATENCY);
    end
    @(negedge Clk);
    Start = 1'b0;
    for (int c = 0; c < LATENCY + 10; c++) begin
      if (Done === 1'b1 || HI_Ld === 1'b1) pulses++;
      @(negedge Clk);
    end
    vectors++;
    if (pulses != 1 || {HI_out, LO_out} !== exp) begin
      miscompares++;
      $display("FAIL b2b_ignored: %0d Done pulses, out=%h_%h expected 1 pulse, %h_%h",
               pulses, HI_out, LO_out, exp[63:32], exp[31:0]);
    end
    $display("back-to-back: pulses=%0d HI_out=%h LO_out=%h", pulses, HI_out, LO_out);
  endtask

  task automatic test_reset_mid_run;
    int pulses;
    // Leave a non-zero result on the outputs so the clear is visible.
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    launch(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0, 32'h0);
    repeat (9) @(negedge Clk);
    Clr = 1'b0;
    #1;
    vectors++;
    if ({Busy, Done, HI_Ld, LO_Ld} !== 4'b0000 || HI_out !== '0 || LO_out !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run: {Busy,Done,HI_Ld,LO_Ld}=%b HI_out=%h LO_out=%h expected all zero",
               {Busy, Done, HI_Ld, LO_Ld}, HI_out, LO_out);
    end
    @(negedge Clk);
    Clr    = 1'b1;
    pulses = 0;
    for (int c = 0; c < LATENCY + 10; c++) begin
      if (HI_Ld === 1'b1 || LO_Ld === 1'b1 || Busy === 1'b1) pulses++;
      @(negedge Clk);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL reset_abort: %0d cycles of Busy/strobe after abort, expected 0", pulses);
    end
    $display("reset mid-run: post-abort activity cycles=%0d", pulses);
    // The unit must be usable again straight away.
    run_op(3'd3, 32'd1000, 32'd33, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_reserved_op;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
